pmt_rotate_stage: RTL and testbench
===================================

Name: pmt_rotate_stage

Overview:
Parametrised streaming permutation stage for the FFT datapath. It routes NUM_LANES complex lanes (x,y pairs) through a cyclic-rotation network. The rotation amount advances every HOLD valid beats after a frame-start pulse. The stage sits between butterfly columns and supersedes the fixed 4-lane upper/lower permutation units: rotation direction is a per-frame mode, and it adds valid qualification, stall tolerance and an optional output register.

Parameters:
DATA_WIDTH, 16, bit width of each real or imaginary component
NUM_LANES, 4, number of complex lanes; power of 2, range 2..16
LOG2_LANES, 2, log2(NUM_LANES); width of the rotation amount
HOLD, 4, valid beats per rotation step (PROBLEM_SIZE/16 for the 4-lane 64-point case); must be ≥1
OUT_REG, 1, 1 = registered outputs (latency 1); 0 = combinational data path (latency 0)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
valid_in  in  1  data_in beat valid
ctrl_in  in  1  frame start; qualified by valid_in
dir_in  in  1  rotation direction; sampled on the frame-start beat; 0 = upper pattern, 1 = lower pattern
data_in  in  2*DATA_WIDTH*NUM_LANES  lane k occupies bits [(2k+2)*DATA_WIDTH-1 : 2k*DATA_WIDTH]; x in the upper half, y in the lower half
data_out  out  2*DATA_WIDTH*NUM_LANES  permuted lanes; same packing as data_in
valid_out  out  1  data_out valid
ctrl_out  out  1  ctrl_in delayed to align with data_out
rot_out  out  LOG2_LANES  rotation amount applied to the current data_out beat

Behaviour:
- Reset: rot=0, hold_cnt=0, active=0, dir_q=0. If OUT_REG=1: data_out=0, valid_out=0, ctrl_out=0, rot_out=0.
- A beat is a cycle with valid_in=1. Cycles with valid_in=0 are stalls: hold_cnt, rot and active are frozen.
- Permutation for a beat using rotation r:
  - dir_q=0: out lane k = in lane (k+r) mod NUM_LANES.
  - dir_q=1: out lane k = in lane (k−r) mod NUM_LANES.
  - x and y of a lane always move together.
- Frame start (valid_in=1 and ctrl_in=1):
  - The beat itself is permuted with r=0 and with dir_in directly (not dir_q).
  - Next state: dir_q←dir_in, active←1, rot←0, hold_cnt←1. If HOLD=1, instead rot←1 and hold_cnt←0.
- Normal beat (active=1, ctrl_in=0):
  - Uses the current rot and dir_q.
  - If hold_cnt==HOLD−1: hold_cnt←0 and rot←rot+1 mod NUM_LANES (wraps to 0 after NUM_LANES−1).
  - Otherwise hold_cnt←hold_cnt+1.
- Free-running: after HOLD*NUM_LANES beats the rotation wraps to 0 and keeps cycling until the next ctrl_in. No automatic stop.
- ctrl_in mid-frame restarts immediately per the frame-start rule; partial progress is discarded.
- active=0 (before the first ctrl_in after reset): rot is held at 0, giving pass-through; hold_cnt does not advance.
- ctrl_in with valid_in=0 is ignored.
- Latency:
  - OUT_REG=1: data_out, valid_out, ctrl_out and rot_out present beat n one cycle after its input. On stall cycles valid_out=0 and data_out holds its last value.
  - OUT_REG=0: all outputs are combinational from the inputs and current state. valid_out=valid_in, ctrl_out=ctrl_in&valid_in.
- rst asserted mid-frame: state returns to reset values on the next edge. No output beat is produced for the reset cycle.
- Synthesis: hold_cnt width is max(1,clog2(HOLD)). The mux tree is NUM_LANES-to-1 per lane with width 2*DATA_WIDTH.

Test Plan:
(Defaults NUM_LANES=4, HOLD=4, OUT_REG=1; lane k data x=16'h10k0, y=16'h20k0 unless stated.)
1. Reset, then 3 beats without ctrl_in -> data_out equals data_in (pass-through), rot_out=0, valid_out follows valid_in by 1 cycle; after reset all outputs are 0.
2. ctrl_in with dir_in=0, then 16 continuous beats -> rot_out sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3. At rot=1, out lane0=in lane1 and out lane3=in lane0. Beat 17 -> rot_out=0 (wrap).
3. Same stimulus with dir_in=1 -> at rot=1, out lane0=in lane3 and out lane1=in lane0. At rot=2, out lane k=in lane (k+2) mod 4.
4. Frame with valid_in deasserted 3 cycles after beat 5 -> valid_out=0 for 3 cycles, data_out frozen. Beats 6–8 still use rot=1; beat 9 uses rot=2.
5. ctrl_in reasserted on beat 10 with dir_in flipped -> that beat uses rot=0 with the new direction. ctrl_out=1 aligned with it; the next 3 beats stay rot=0.
6. Parameter sweeps: NUM_LANES=8/HOLD=1 -> rot_out steps every beat 0..7 then wraps. OUT_REG=0 -> outputs match the same-cycle inputs. Assert rst mid-frame at beat 7 -> rot_out=0 and pass-through until the next ctrl_in.

Source files
------------

// File: rtl/pmt_rotate_stage.sv
// pmt_rotate_stage: streaming cyclic-rotation permutation stage for the FFT datapath.
// Routes NUM_LANES complex lanes through a rotation network whose amount advances every
// HOLD valid beats after a frame-start pulse. Direction is chosen per frame.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   valid_in      data_in beat valid; cycles without it are stalls
//   ctrl_in       frame start, qualified by valid_in
//   dir_in        rotation direction, sampled on the frame-start beat (0 upper, 1 lower)
//   data_in       NUM_LANES packed lanes, lane k at [(2k+2)*DW-1 : 2k*DW], x high / y low
//   data_out      permuted lanes, same packing
//   valid_out     data_out valid
//   ctrl_out      ctrl_in aligned with data_out
//   rot_out       rotation applied to the current data_out beat
module pmt_rotate_stage #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned LOG2_LANES = 2,
    parameter int unsigned HOLD       = 4,
    parameter int unsigned OUT_REG    = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 valid_in,
    input  logic                                 ctrl_in,
    input  logic                                 dir_in,
    input  logic [2*DATA_WIDTH*NUM_LANES-1:0]    data_in,
    output logic [2*DATA_WIDTH*NUM_LANES-1:0]    data_out,
    output logic                                 valid_out,
    output logic                                 ctrl_out,
    output logic [LOG2_LANES-1:0]                rot_out
);

    localparam int unsigned LANE_W = 2 * DATA_WIDTH;
    localparam int unsigned BUS_W  = LANE_W * NUM_LANES;
    localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

    logic [LOG2_LANES-1:0] rot;
    logic [HOLD_W-1:0]     hold_cnt;
    logic                  active;
    logic                  dir_q;

    logic                  start_c;
    logic [LOG2_LANES-1:0] rot_c;
    logic                  dir_c;
    logic [BUS_W-1:0]      perm_c;
    logic [LANE_W-1:0]     lane_in [NUM_LANES];

    // A frame-start beat is itself permuted with r=0 and the fresh direction.
    always_comb begin
        start_c = valid_in & ctrl_in;
        rot_c   = start_c ? '0 : rot;
        dir_c   = start_c ? dir_in : dir_q;
    end

    // Rotation network: each output lane selects one input lane; x and y move together.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [LOG2_LANES-1:0] src;
        assign lane_in[k] = data_in[k*LANE_W +: LANE_W];
        // Lane count is a power of two, so index arithmetic wraps modulo NUM_LANES.
        assign src = dir_c ? (LOG2_LANES'(k) - rot_c) : (LOG2_LANES'(k) + rot_c);
        assign perm_c[k*LANE_W +: LANE_W] = lane_in[src];
    end

    // Rotation sequencer; frozen on stalls and held at pass-through until the first frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            rot      <= '0;
            hold_cnt <= '0;
            active   <= 1'b0;
            dir_q    <= 1'b0;
        end else if (start_c) begin
            dir_q  <= dir_in;
            active <= 1'b1;
            if (HOLD == 1) begin
                rot      <= LOG2_LANES'(1);
                hold_cnt <= '0;
            end else begin
                rot      <= '0;
                hold_cnt <= HOLD_W'(1);
            end
        end else if (valid_in && active) begin
            if (hold_cnt == HOLD_LAST) begin
                hold_cnt <= '0;
                rot      <= rot + LOG2_LANES'(1);
            end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        // One-cycle output register; data and rotation hold across stalls.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_out  <= '0;
                valid_out <= 1'b0;
                ctrl_out  <= 1'b0;
                rot_out   <= '0;
            end else begin
                valid_out <= valid_in;
                ctrl_out  <= start_c;
                if (valid_in) begin
                    data_out <= perm_c;
                    rot_out  <= rot_c;
                end
            end
        end
    end else begin : g_out_comb
        assign data_out  = perm_c;
        assign valid_out = valid_in;
        assign ctrl_out  = start_c;
        assign rot_out   = rot_c;
    end

endmodule

// File: tb/tb_pmt_rotate_stage.sv
// Self-checking bench for pmt_rotate_stage: a registered 4-lane instance and a
// combinational 4-lane instance share one directed vector table; an 8-lane HOLD=1
// instance gets a hand-written sequence.
module tb_pmt_rotate_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the 4-lane instances.
    logic         rst, v, c, d;
    logic [127:0] din;
    logic [127:0] dout0, dout2;
    logic         vout0, cout0, vout2, cout2;
    logic [1:0]   rot0, rot2;

    // 8-lane, HOLD=1 instance.
    logic         rst1, v1, c1, d1;
    logic [255:0] din1, dout1;
    logic         vout1, cout1;
    logic [2:0]   rot1;

    pmt_rotate_stage #(.DATA_WIDTH(16), .NUM_LANES(4), .LOG2_LANES(2), .HOLD(4), .OUT_REG(1)) u_reg (
        .clk(clk), .rst(rst), .valid_in(v), .ctrl_in(c), .dir_in(d), .data_in(din),
        .data_out(dout0), .valid_out(vout0), .ctrl_out(cout0), .rot_out(rot0));

    pmt_rotate_stage #(.DATA_WIDTH(16), .NUM_LANES(4), .LOG2_LANES(2), .HOLD(4), .OUT_REG(0)) u_comb (
        .clk(clk), .rst(rst), .valid_in(v), .ctrl_in(c), .dir_in(d), .data_in(din),
        .data_out(dout2), .valid_out(vout2), .ctrl_out(cout2), .rot_out(rot2));

    pmt_rotate_stage #(.DATA_WIDTH(16), .NUM_LANES(8), .LOG2_LANES(3), .HOLD(1), .OUT_REG(1)) u_wide (
        .clk(clk), .rst(rst1), .valid_in(v1), .ctrl_in(c1), .dir_in(d1), .data_in(din1),
        .data_out(dout1), .valid_out(vout1), .ctrl_out(cout1), .rot_out(rot1));

    typedef struct {
        bit rst;
        bit v;
        bit c;
        bit d;
        bit ev;     // expected valid_out
        bit ec;     // expected ctrl_out
        int er;     // expected rotation for this beat
        bit ed;     // expected effective direction for this beat
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Lane k of beat b: x = 1 k bb, y = 2 k bb (hex nibbles).
    function automatic logic [255:0] mk(input int n, input int b);
        logic [255:0] o;
        o = '0;
        for (int k = 0; k < n; k++)
            o[k*32 +: 32] = {4'h1, 4'(k), 8'(b), 4'h2, 4'(k), 8'(b)};
        return o;
    endfunction

    function automatic logic [255:0] perm(input int n, input logic [255:0] x, input int r, input bit dir);
        logic [255:0] o;
        int src;
        o = '0;
        for (int k = 0; k < n; k++) begin
            src = dir ? ((k - r + n) % n) : ((k + r) % n);
            o[k*32 +: 32] = x[src*32 +: 32];
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic add(input bit r_, input bit v_, input bit c_, input bit d_,
                       input bit ev_, input bit ec_, input int er_, input bit ed_);
        vec_t e;
        e.rst = r_; e.v = v_; e.c = c_; e.d = d_;
        e.ev = ev_; e.ec = ec_; e.er = er_; e.ed = ed_;
        tbl.push_back(e);
    endtask

    // Continuous frame; non-start beats drive the opposite dir_in to prove it is latched.
    task automatic add_frame(input bit dir, input int nbeats);
        for (int j = 0; j < nbeats; j++)
            add(1'b0, 1'b1, j == 0, (j == 0) ? dir : ~dir, 1'b1, j == 0, (j / 4) % 4, dir);
    endtask

    initial begin
        logic [255:0] hold_data;
        int           hold_rot;
        logic [255:0] exp_d;
        vec_t         e;

        rst = 1'b1; v = 1'b0; c = 1'b0; d = 1'b0; din = '0;
        rst1 = 1'b1; v1 = 1'b0; c1 = 1'b0; d1 = 1'b0; din1 = '0;

        // Reset, then pass-through beats before any frame start.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 3; j++) add(0, 1, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // Upper and lower frames of 17 beats each (beat 17 wraps to rot 0).
        add_frame(1'b0, 17);
        add_frame(1'b1, 17);
        // Stall after beat 5, with an ignored ctrl_in during the stall.
        for (int j = 0; j < 5; j++) add(0, 1, j == 0, 0, 1, j == 0, j / 4, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 1, 0);
        add(0, 1, 0, 0, 1, 0, 1, 0);
        add(0, 1, 0, 0, 1, 0, 1, 0);
        add(0, 1, 0, 0, 1, 0, 2, 0);
        // Restart on beat 10 with the direction flipped.
        add(0, 1, 1, 1, 1, 1, 0, 1);
        add(0, 1, 0, 0, 1, 0, 0, 1);
        add(0, 1, 0, 0, 1, 0, 0, 1);
        add(0, 1, 0, 0, 1, 0, 0, 1);
        add(0, 1, 0, 0, 1, 0, 1, 1);
        // Reset during a frame on beat 7, then pass-through until the next start.
        add_frame(1'b1, 6);
        add(1, 1, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 4; j++) add(0, 1, 0, 1, 1, 0, 0, 0);
        add_frame(1'b0, 6);

        hold_data = '0;
        hold_rot  = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            e = tbl[i];
            @(negedge clk);
            rst = e.rst; v = e.v; c = e.c; d = e.d;
            din = 128'(mk(4, i));
            #1;
            // Combinational instance reflects the same-cycle beat.
            if (!e.rst) begin
                chk($sformatf("comb_valid[%0d]", i), 256'(vout2), 256'(e.v));
                chk($sformatf("comb_ctrl[%0d]", i), 256'(cout2), 256'(e.v & e.c));
                if (e.v) begin
                    chk($sformatf("comb_rot[%0d]", i), 256'(rot2), 256'(e.er));
                    chk($sformatf("comb_data[%0d]", i), 256'(dout2), perm(4, mk(4, i), e.er, e.ed));
                end
            end
            @(posedge clk);
            #1;
            if (e.rst) begin
                hold_data = '0;
                hold_rot  = 0;
            end else if (e.ev) begin
                hold_data = perm(4, mk(4, i), e.er, e.ed);
                hold_rot  = e.er;
            end
            exp_d = hold_data;
            chk($sformatf("reg_valid[%0d]", i), 256'(vout0), 256'(e.ev));
            chk($sformatf("reg_ctrl[%0d]", i), 256'(cout0), 256'(e.ec));
            chk($sformatf("reg_rot[%0d]", i), 256'(rot0), 256'(hold_rot));
            chk($sformatf("reg_data[%0d]", i), 256'(dout0), exp_d);
        end

        // 8 lanes, HOLD=1: rotation steps every beat and wraps after 7.
        @(negedge clk);
        rst = 1'b0; v = 1'b0; c = 1'b0;
        rst1 = 1'b1;
        @(posedge clk);
        #1;
        chk("wide_reset_valid", 256'(vout1), 256'(0));
        chk("wide_reset_rot", 256'(rot1), 256'(0));
        chk("wide_reset_data", dout1, 256'(0));
        for (int j = 0; j < 13; j++) begin
            @(negedge clk);
            rst1 = 1'b0; v1 = 1'b1;
            c1   = (j == 0) || (j == 10);
            d1   = (j >= 10);
            din1 = mk(8, j);
            @(posedge clk);
            #1;
            chk($sformatf("wide_valid[%0d]", j), 256'(vout1), 256'(1));
            chk($sformatf("wide_ctrl[%0d]", j), 256'(cout1), 256'((j == 0) || (j == 10)));
            if (j < 10) begin
                chk($sformatf("wide_rot[%0d]", j), 256'(rot1), 256'(j % 8));
                chk($sformatf("wide_data[%0d]", j), dout1, perm(8, mk(8, j), j % 8, 1'b0));
            end else begin
                chk($sformatf("wide_rot[%0d]", j), 256'(rot1), 256'(j - 10));
                chk($sformatf("wide_data[%0d]", j), dout1, perm(8, mk(8, j), j - 10, 1'b1));
            end
        end
        @(negedge clk);
        v1 = 1'b0;
        @(posedge clk);
        #1;
        chk("wide_stall_valid", 256'(vout1), 256'(0));
        chk("wide_stall_data", dout1, perm(8, mk(8, 12), 2, 1'b1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
